// File: rtl/alu_uart_sequencer_pkg.sv
// Shared constants for the UART-fed ALU frame sequencer: state codes,
// default timeout and the alu opcodes that frames carry.
package alu_uart_sequencer_pkg;
  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_WAIT_A   = 3'b000;
  localparam logic [ST_W-1:0] ST_WAIT_B   = 3'b001;
  localparam logic [ST_W-1:0] ST_WAIT_OP  = 3'b010;
  localparam logic [ST_W-1:0] ST_EXEC     = 3'b011;
  localparam logic [ST_W-1:0] ST_TX_START = 3'b100;
  localparam logic [ST_W-1:0] ST_WAIT_TX  = 3'b101;

  localparam int DEF_TIMEOUT_CYCLES = 10_000_000;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
endpackage

// File: rtl/alu_uart_sequencer_frame_timeout_counter.sv
// Inter-byte idle counter; expire is high during the last allowed idle cycle.
module alu_uart_sequencer_frame_timeout_counter #(
  parameter int NB_TIMEOUT     = 24,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic expire
);
  localparam logic [NB_TIMEOUT-1:0] LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMEOUT-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign expire = enable && (count == LAST);
endmodule

// File: rtl/alu_uart_sequencer.sv
// Collects operand A, operand B and opcode from the UART receiver, runs the
// external alu for one cycle and hands the result to the UART transmitter.
module alu_uart_sequencer
  import alu_uart_sequencer_pkg::*;
#(
  parameter int NB_DATA_BUS    = 8,
  parameter int NB_OPCODE      = 6,
  parameter int NB_DBG_LED     = 3,
  parameter int NB_TIMEOUT     = 24,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic [NB_DATA_BUS-1:0] i_rx_data,
  input  logic                   i_rx_done,
  input  logic [NB_DATA_BUS-1:0] i_alu_result,
  input  logic                   i_tx_done,
  output logic [NB_DATA_BUS-1:0] o_first_operator,
  output logic [NB_DATA_BUS-1:0] o_second_operator,
  output logic [NB_OPCODE-1:0]   o_opcode,
  output logic [NB_DATA_BUS-1:0] o_tx_data,
  output logic                   o_tx_start,
  output logic                   o_busy,
  output logic                   o_rx_drop,
  output logic [NB_DBG_LED-1:0]  o_led_dbg
);
  logic [ST_W-1:0] state, next_state;
  logic accept, drop, tmo_en, tmo_clr, tmo_expire;

  alu_uart_sequencer_frame_timeout_counter #(
    .NB_TIMEOUT     (NB_TIMEOUT),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (i_clock),
    .reset_n (i_reset_n),
    .enable  (tmo_en),
    .clear   (tmo_clr),
    .expire  (tmo_expire)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_WAIT_A;
    else            state <= next_state;
  end

  // A byte on the expiry cycle wins over the timeout.
  always_comb begin
    next_state = state;
    case (state)
      ST_WAIT_A:   if (i_rx_done) next_state = ST_WAIT_B;
      ST_WAIT_B:   if (i_rx_done) next_state = ST_WAIT_OP;
                   else if (tmo_expire) next_state = ST_WAIT_A;
      ST_WAIT_OP:  if (i_rx_done) next_state = ST_EXEC;
                   else if (tmo_expire) next_state = ST_WAIT_A;
      ST_EXEC:     next_state = ST_TX_START;
      ST_TX_START: next_state = ST_WAIT_TX;
      ST_WAIT_TX:  if (i_tx_done) next_state = ST_WAIT_A;
      default:     next_state = ST_WAIT_A;
    endcase
  end

  always_comb begin
    o_busy  = (state == ST_EXEC) || (state == ST_TX_START) || (state == ST_WAIT_TX);
    accept  = i_rx_done && !o_busy;
    drop    = i_rx_done && o_busy;
    tmo_en  = (state == ST_WAIT_B) || (state == ST_WAIT_OP);
    tmo_clr = accept || (state == ST_WAIT_A);
    o_led_dbg = NB_DBG_LED'(state);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_first_operator  <= '0;
      o_second_operator <= '0;
      o_opcode          <= '0;
      o_tx_data         <= '0;
      o_tx_start        <= 1'b0;
      o_rx_drop         <= 1'b0;
    end else begin
      if (accept) begin
        case (state)
          ST_WAIT_A:  o_first_operator  <= i_rx_data;
          ST_WAIT_B:  o_second_operator <= i_rx_data;
          ST_WAIT_OP: o_opcode          <= i_rx_data[NB_OPCODE-1:0];
          default: ;
        endcase
      end
      if (state == ST_EXEC) o_tx_data <= i_alu_result;
      // Flopped from next_state so the request lines up with TX_START.
      o_tx_start <= (next_state == ST_TX_START);
      if (drop) o_rx_drop <= 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer with a behavioural alu next to it.
module tb_alu_uart_sequencer;
  import alu_uart_sequencer_pkg::*;

  localparam int TMO = 16;

  logic       i_clock = 1'b0;
  logic       i_reset_n = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic       i_rx_done = 1'b0;
  logic [7:0] i_alu_result;
  logic       i_tx_done = 1'b0;
  logic [7:0] o_first_operator, o_second_operator, o_tx_data;
  logic [5:0] o_opcode;
  logic       o_tx_start, o_busy, o_rx_drop;
  logic [2:0] o_led_dbg;

  int n_checks = 0;
  int n_fails  = 0;
  int n_starts = 0;

  always #5 i_clock = ~i_clock;

  alu_uart_sequencer #(
    .NB_DATA_BUS(8), .NB_OPCODE(6), .NB_DBG_LED(3),
    .NB_TIMEOUT(24), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clock           (i_clock),
    .i_reset_n         (i_reset_n),
    .i_rx_data         (i_rx_data),
    .i_rx_done         (i_rx_done),
    .i_alu_result      (i_alu_result),
    .i_tx_done         (i_tx_done),
    .o_first_operator  (o_first_operator),
    .o_second_operator (o_second_operator),
    .o_opcode          (o_opcode),
    .o_tx_data         (o_tx_data),
    .o_tx_start        (o_tx_start),
    .o_busy            (o_busy),
    .o_rx_drop         (o_rx_drop),
    .o_led_dbg         (o_led_dbg)
  );

  always_comb begin
    case (o_opcode)
      OP_ADD:  i_alu_result = o_first_operator + o_second_operator;
      OP_SUB:  i_alu_result = o_first_operator - o_second_operator;
      OP_AND:  i_alu_result = o_first_operator & o_second_operator;
      OP_OR:   i_alu_result = o_first_operator | o_second_operator;
      default: i_alu_result = 8'h00;
    endcase
  end

  always @(negedge i_clock) if (o_tx_start === 1'b1) n_starts++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b; i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a"},     32'(o_first_operator), 32'h0);
    chk({tag, "_b"},     32'(o_second_operator), 32'h0);
    chk({tag, "_op"},    32'(o_opcode), 32'h0);
    chk({tag, "_txd"},   32'(o_tx_data), 32'h0);
    chk({tag, "_start"}, 32'(o_tx_start), 32'h0);
    chk({tag, "_busy"},  32'(o_busy), 32'h0);
    chk({tag, "_drop"},  32'(o_rx_drop), 32'h0);
    chk({tag, "_led"},   32'(o_led_dbg), 32'h0);
  endtask

  // Sends a full frame and follows it through EXEC/TX_START into WAIT_TX.
  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp_res);
    int s0;
    send_byte(a);
    send_byte(b);
    s0 = n_starts;
    send_byte(op);
    chk({tag, "_exec"}, 32'(o_led_dbg), 32'h3);
    chk({tag, "_opc"},  32'(o_opcode), 32'(op[5:0]));
    tick();
    chk({tag, "_txs_led"}, 32'(o_led_dbg), 32'h4);
    chk({tag, "_start"},   32'(o_tx_start), 32'h1);
    chk({tag, "_res"},     32'(o_tx_data), 32'(exp_res));
    repeat (3) tick();
    chk({tag, "_waittx"},  32'(o_led_dbg), 32'h5);
    chk({tag, "_busy"},    32'(o_busy), 32'h1);
    chk({tag, "_npulse"},  32'(n_starts - s0), 32'h1);
  endtask

  initial begin
    repeat (2) @(posedge i_clock);
    #1;
    chk_reset_outputs("rst0");
    i_reset_n = 1'b1;
    tick();

    // ADD 5+3
    run_frame("add", 8'h05, 8'h03, 8'h20, 8'h08);
    pulse_tx_done();
    chk("add_idle", 32'(o_led_dbg), 32'h0);

    // SUB with upper opcode bits set
    run_frame("sub", 8'h03, 8'h05, 8'hE2, 8'hFE);
    chk("sub_opc6", 32'(o_opcode), 32'h22);
    pulse_tx_done();

    // Partial frame times out after TMO idle cycles in WAIT_B
    send_byte(8'h11);
    chk("tmo_wb", 32'(o_led_dbg), 32'h1);
    repeat (TMO - 1) tick();
    chk("tmo_hold", 32'(o_led_dbg), 32'h1);
    tick();
    chk("tmo_abort", 32'(o_led_dbg), 32'h0);
    chk("tmo_keep_a", 32'(o_first_operator), 32'h11);
    run_frame("or", 8'h0F, 8'hF0, 8'h25, 8'hFF);

    // Byte while waiting for the transmitter is dropped
    send_byte(8'h77);
    chk("drop_flag", 32'(o_rx_drop), 32'h1);
    chk("drop_state", 32'(o_led_dbg), 32'h5);
    chk("drop_a", 32'(o_first_operator), 32'h0F);
    pulse_tx_done();
    chk("drop_idle", 32'(o_led_dbg), 32'h0);
    run_frame("and", 8'h0C, 8'h0A, 8'h24, 8'h08);

    // rx and tx done together in WAIT_TX: leave, but the byte is not operand A
    i_rx_data = 8'h99; i_rx_done = 1'b1; i_tx_done = 1'b1;
    tick();
    i_rx_done = 1'b0; i_tx_done = 1'b0;
    chk("both_state", 32'(o_led_dbg), 32'h0);
    chk("both_a", 32'(o_first_operator), 32'h0C);
    tick();
    chk("both_still_a", 32'(o_led_dbg), 32'h0);

    // Async reset in WAIT_OP
    send_byte(8'h21);
    send_byte(8'h22);
    chk("rop_state", 32'(o_led_dbg), 32'h2);
    i_reset_n = 1'b0; #1;
    chk_reset_outputs("rop");
    tick();
    i_reset_n = 1'b1;
    tick();

    // Async reset in TX_START, no late start pulse after release
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    tick();
    chk("rtx_state", 32'(o_led_dbg), 32'h4);
    begin
      int s0;
      s0 = n_starts;
      i_reset_n = 1'b0; #1;
      chk_reset_outputs("rtx");
      tick();
      i_reset_n = 1'b1;
      repeat (4) tick();
      chk("rtx_nopulse", 32'(n_starts - s0), 32'h0);
      chk("rtx_idle", 32'(o_led_dbg), 32'h0);
    end

    // Byte arriving on the exact expiry cycle is accepted
    send_byte(8'h33);
    repeat (TMO - 1) tick();
    chk("edge_pre", 32'(o_led_dbg), 32'h1);
    send_byte(8'h42);
    chk("edge_state", 32'(o_led_dbg), 32'h2);
    chk("edge_b", 32'(o_second_operator), 32'h42);
    repeat (TMO - 1) tick();
    chk("edge_op_hold", 32'(o_led_dbg), 32'h2);
    tick();
    chk("edge_op_abort", 32'(o_led_dbg), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
